lock_timer_ctrl: RTL
====================

// Module: lock_timer_ctrl
// PURPOSE
//  Sequences one shared prescaler instance (ce/clr/co ports, period P = 2**W clk)
//  for the lock's two timed jobs: door-open hold (job 0) and bad-code lockout (job 1).
//  Arbitrates the two requesters, clears and starts the prescaler, counts its periods,
//  and reports completion or abort. It sits between the lock FSM and the prescaler.
// PARAMETERS
//  CNT_W      8  width of the period counter and of the remaining output
//  OPEN_TICKS 5  prescaler periods for job 0; legal 1..2**CNT_W-1
//  LOCK_TICKS 30 prescaler periods for job 1; legal 1..2**CNT_W-1
// PORTS
//  clk        in  1      system clock, all state on posedge
//  clr_n      in  1      asynchronous, active-low reset
//  req        in  2      single-cycle start pulses; bit0 = open hold, bit1 = lockout
//  cancel     in  1      single-cycle abort of the running job
//  pre_co     in  1      prescaler co (count MSB | ~ce)
//  pre_ce     out 1      prescaler ce
//  pre_clr    out 1      prescaler clr (synchronous)
//  grant      out 2      one-hot owner of the prescaler; 00 when idle
//  busy       out 1      a job is in CLEAR or RUN
//  remaining  out CNT_W  periods still to elapse for the current job
//  done       out 2      one-cycle pulse: job completed normally
//  aborted    out 2      one-cycle pulse: job cancelled or pre-empted
// BEHAVIOUR
//  Reset (clr_n=0, async): state=IDLE; every output 0; co_q=0, ce_q=0.
//  States: IDLE, CLEAR, RUN. All outputs are registered.
//  IDLE: pre_ce=0, pre_clr=0. If req!=0, go to CLEAR next cycle. req[1] wins over req[0].
//    grant=winner; remaining=LOCK_TICKS or OPEN_TICKS. cancel is ignored.
//  CLEAR (1 cycle): pre_clr=1, pre_ce=0. Always go to RUN.
//  RUN: pre_ce=1, pre_clr=0.
//  Tick = co_q & ~pre_co & ce_q & pre_ce, where co_q/ce_q are pre_co/pre_ce delayed 1 clk.
//    This is the co falling edge at the prescaler wrap. It excludes the ~ce artefact.
//    The first tick comes P cycles after RUN entry, then one tick every P cycles.
//  On a tick, remaining decrements. If remaining==1 at the tick: go to IDLE.
//    done[grant] is high for the next cycle; grant, busy and remaining clear.
//  Priority in RUN, highest first: cancel > pre-empt > tick.
//    cancel: go to IDLE; aborted[grant] pulses; no done; any same-cycle req is dropped.
//    pre-empt: job 0 running and req[1]=1 -> aborted[0] pulses and CLEAR starts for job 1.
//      This applies even on the final tick: no done[0].
//    While job 1 runs, req[0] is dropped with no indication. req[1] during job 1 is ignored,
//      so there is no retrigger.
//  A completion tick and a new req in the same cycle: the done pulse is issued and the req
//    is dropped. Requesters re-request after done.
//  done and aborted are never both high. grant is always one-hot or 00.
//  remaining never wraps: a decrement only occurs when remaining >= 1.
//  Reset mid-job: immediate IDLE. The prescaler count is don't-care; every job re-clears it.
// TESTING  (W=3 so P=8, OPEN_TICKS=2, LOCK_TICKS=3; req pulse at cycle 0)
//  reset held for 3 cycles mid-RUN -> all outputs 0 asynchronously; IDLE after release.
//  req=01 -> c1: pre_clr=1, grant=01, remaining=2. c2..: pre_ce=1.
//    Ticks at c10 and c18. done=01 at c19 only; busy=0 at c19.
//  req=11 -> grant=10, remaining=3; done=10 at c27; no activity on job 0.
//  req=01, then req=10 at c5 -> aborted=01 at c6, pre_clr=1 at c6, grant=10.
//    done=10 at c32.
//  req=10, cancel at c12 -> aborted=10 at c13, pre_ce=0, remaining=0; no done.
//  req=01, with req=01 again at c9 and req[0] during job 1 -> ignored.
//    The single done=01 pulse is unchanged at c19.

Source files
------------

// File: rtl/lock_timer_ctrl.sv
// Purpose: arbitrates the door-open hold and lockout jobs onto one shared prescaler and counts its periods.
// Latency: all outputs are registered; CLEAR is issued the cycle after a req and the first tick arrives P cycles into RUN.
// Backpressure: none; requests that lose arbitration or arrive while busy are dropped, and requesters re-request after done.
module lock_timer_ctrl #(
    parameter int CNT_W      = 8,
    parameter int OPEN_TICKS = 5,
    parameter int LOCK_TICKS = 30
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [1:0]       req,
    input  logic             cancel,
    input  logic             pre_co,
    output logic             pre_ce,
    output logic             pre_clr,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic [1:0]       done,
    output logic [1:0]       aborted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] OPEN_R = CNT_W'(OPEN_TICKS);
    localparam logic [CNT_W-1:0] LOCK_R = CNT_W'(LOCK_TICKS);

    state_t             state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         done_q, done_d;
    logic [1:0]         aborted_q, aborted_d;
    logic               pre_ce_q, pre_ce_d;
    logic               pre_clr_q, pre_clr_d;
    logic               co_q;
    logic               ce_q;
    logic               tick;

    // A period ends where co falls while ce stayed high; the low-ce forced co is not a wrap.
    assign tick = co_q & ~pre_co & ce_q & pre_ce_q;

    // Next-state and next-output decode; everything lands in registers.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        busy_d      = busy_q;
        remaining_d = remaining_q;
        done_d      = 2'b00;
        aborted_d   = 2'b00;
        pre_ce_d    = 1'b0;
        pre_clr_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                grant_d     = 2'b00;
                busy_d      = 1'b0;
                remaining_d = '0;
                if (req[1]) begin
                    state_d     = ST_CLEAR;
                    grant_d     = 2'b10;
                    busy_d      = 1'b1;
                    remaining_d = LOCK_R;
                    pre_clr_d   = 1'b1;
                end else if (req[0]) begin
                    state_d     = ST_CLEAR;
                    grant_d     = 2'b01;
                    busy_d      = 1'b1;
                    remaining_d = OPEN_R;
                    pre_clr_d   = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d  = ST_RUN;
                pre_ce_d = 1'b1;
            end
            ST_RUN: begin
                pre_ce_d = 1'b1;
                if (cancel) begin
                    state_d     = ST_IDLE;
                    aborted_d   = grant_q;
                    grant_d     = 2'b00;
                    busy_d      = 1'b0;
                    remaining_d = '0;
                    pre_ce_d    = 1'b0;
                end else if (grant_q[0] && req[1]) begin
                    // Lockout pre-empts the open hold, even on its final tick.
                    state_d     = ST_CLEAR;
                    aborted_d   = 2'b01;
                    grant_d     = 2'b10;
                    remaining_d = LOCK_R;
                    pre_ce_d    = 1'b0;
                    pre_clr_d   = 1'b1;
                end else if (tick) begin
                    if (remaining_q == CNT_W'(1)) begin
                        state_d     = ST_IDLE;
                        done_d      = grant_q;
                        grant_d     = 2'b00;
                        busy_d      = 1'b0;
                        remaining_d = '0;
                        pre_ce_d    = 1'b0;
                    end else if (remaining_q != '0) begin
                        remaining_d = remaining_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_IDLE;
                grant_d     = 2'b00;
                busy_d      = 1'b0;
                remaining_d = '0;
            end
        endcase
    end

    // State and output registers, plus the one-cycle history used for edge detection.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            remaining_q <= '0;
            done_q      <= 2'b00;
            aborted_q   <= 2'b00;
            pre_ce_q    <= 1'b0;
            pre_clr_q   <= 1'b0;
            co_q        <= 1'b0;
            ce_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
            pre_ce_q    <= pre_ce_d;
            pre_clr_q   <= pre_clr_d;
            co_q        <= pre_co;
            ce_q        <= pre_ce_q;
        end
    end

    assign pre_ce    = pre_ce_q;
    assign pre_clr   = pre_clr_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign remaining = remaining_q;
    assign done      = done_q;
    assign aborted   = aborted_q;

endmodule
